// File: rtl/uart_word_serdes.sv
// Word/byte converter between the UART byte FIFOs and the register side.
// TX splits a DATA_W word into bytes LSB first; RX reassembles words with an inter-byte timeout.
module uart_word_serdes #(
    parameter int DATA_W      = 11,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sw_rst,
    input  logic [DATA_W-1:0] word_in_data,
    input  logic              word_in_valid,
    output logic              word_in_ready,
    output logic [7:0]        byte_out_data,
    output logic              byte_out_valid,
    input  logic              byte_out_ready,
    input  logic [7:0]        byte_in_data,
    input  logic              byte_in_valid,
    output logic              byte_in_ready,
    output logic [DATA_W-1:0] word_out_data,
    output logic              word_out_valid,
    input  logic              word_out_ready,
    output logic              tx_busy,
    output logic              rx_busy,
    output logic              rx_timeout_err
);

    localparam int NB = (DATA_W + 7) / 8;
    localparam int PW = NB * 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(NB - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

    tx_state_t         tx_state;
    logic [PW-1:0]     tx_sh;
    logic [CW-1:0]     tx_idx;

    rx_state_t         rx_state;
    logic [CW-1:0]     rx_cnt;
    logic [DATA_W-1:0] rx_buf;
    logic [DATA_W-1:0] asm_word;
    logic [DATA_W-1:0] word_q;
    logic              err_q;
    logic              byte_acc;
    logic              timeout_fire;

    // Readies are gated by sw_rst so a handshake in the soft-reset cycle never happens upstream.
    assign word_in_ready  = en && !sw_rst && (tx_state == TX_IDLE);
    assign byte_out_valid = (tx_state == TX_SEND);
    assign byte_out_data  = tx_sh[7:0];
    assign tx_busy        = (tx_state == TX_SEND);

    assign byte_in_ready  = en && !sw_rst && (rx_state == RX_COLLECT);
    assign byte_acc       = byte_in_valid && byte_in_ready;
    assign word_out_valid = (rx_state == RX_HOLD);
    assign word_out_data  = word_q;
    assign rx_busy        = (rx_cnt != '0);
    assign rx_timeout_err = err_q;

    // TX: the word is held zero-padded in a shift register, so the low byte is always the one on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_idx   <= '0;
        end else if (sw_rst) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_idx   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (word_in_valid && word_in_ready) begin
                        tx_sh    <= PW'(word_in_data);
                        tx_idx   <= '0;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (byte_out_ready) begin
                        tx_sh <= tx_sh >> 8;
                        if (tx_idx == LAST_SLOT) begin
                            tx_idx   <= '0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Partial word with the incoming byte merged into slot rx_cnt; bits above DATA_W fall away here.
    always_comb begin
        // NOTE: default assignment first so no path leaves asm_word unassigned (no latch).
        asm_word = rx_buf;
        for (int b = 0; b < DATA_W; b++) begin
            if (rx_cnt == CW'(b / 8)) asm_word[b] = byte_in_data[b % 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_COLLECT;
            rx_cnt   <= '0;
            rx_buf   <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else if (sw_rst) begin
            rx_state <= RX_COLLECT;
            rx_cnt   <= '0;
            rx_buf   <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (rx_state)
                RX_COLLECT: begin
                    if (byte_acc) begin
                        if (rx_cnt == LAST_SLOT) begin
                            word_q   <= asm_word;
                            rx_buf   <= '0;
                            rx_cnt   <= '0;
                            rx_state <= RX_HOLD;
                        end else begin
                            rx_buf <= asm_word;
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else if (timeout_fire) begin
                        rx_buf <= '0;
                        rx_cnt <= '0;
                        err_q  <= 1'b1;
                    end
                end
                RX_HOLD: begin
                    if (word_out_ready) rx_state <= RX_COLLECT;
                end
                default: rx_state <= RX_COLLECT;
            endcase
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

            logic [TW-1:0] idle_cnt;
            logic          idle_cycle;

            // An accepted byte in the limit cycle suppresses the timeout because idle_cycle is then low.
            assign idle_cycle   = (rx_state == RX_COLLECT) && (rx_cnt != '0) && !byte_acc;
            assign timeout_fire = idle_cycle && (idle_cnt == IDLE_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idle_cnt <= '0;
                end else if (sw_rst || !idle_cycle || timeout_fire) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign timeout_fire = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_uart_word_serdes.sv
// Self-checking bench for uart_word_serdes: directed tables, corner sequences and a
// randomized run against a queue-based reference model, for DATA_W = 11, 32 and 8.
module tb_uart_word_serdes;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT a: DATA_W=11, TIMEOUT_CYC=16
    logic        a_en, a_sw_rst, a_wi_valid, a_wi_ready, a_bo_valid, a_bo_ready;
    logic        a_bi_valid, a_bi_ready, a_wo_valid, a_wo_ready, a_tx_busy, a_rx_busy, a_err;
    logic [10:0] a_wi_data, a_wo_data;
    logic [7:0]  a_bo_data, a_bi_data;

    // DUT b: DATA_W=32, timeout disabled
    logic        b_en, b_sw_rst, b_wi_valid, b_wi_ready, b_bo_valid, b_bo_ready;
    logic        b_bi_valid, b_bi_ready, b_wo_valid, b_wo_ready, b_tx_busy, b_rx_busy, b_err;
    logic [31:0] b_wi_data, b_wo_data;
    logic [7:0]  b_bo_data, b_bi_data;

    // DUT c: DATA_W=8
    logic        c_en, c_sw_rst, c_wi_valid, c_wi_ready, c_bo_valid, c_bo_ready;
    logic        c_bi_valid, c_bi_ready, c_wo_valid, c_wo_ready, c_tx_busy, c_rx_busy, c_err;
    logic [7:0]  c_wi_data, c_wo_data;
    logic [7:0]  c_bo_data, c_bi_data;

    uart_word_serdes #(.DATA_W(11), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .sw_rst(a_sw_rst),
        .word_in_data(a_wi_data), .word_in_valid(a_wi_valid), .word_in_ready(a_wi_ready),
        .byte_out_data(a_bo_data), .byte_out_valid(a_bo_valid), .byte_out_ready(a_bo_ready),
        .byte_in_data(a_bi_data), .byte_in_valid(a_bi_valid), .byte_in_ready(a_bi_ready),
        .word_out_data(a_wo_data), .word_out_valid(a_wo_valid), .word_out_ready(a_wo_ready),
        .tx_busy(a_tx_busy), .rx_busy(a_rx_busy), .rx_timeout_err(a_err)
    );

    uart_word_serdes #(.DATA_W(32), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .sw_rst(b_sw_rst),
        .word_in_data(b_wi_data), .word_in_valid(b_wi_valid), .word_in_ready(b_wi_ready),
        .byte_out_data(b_bo_data), .byte_out_valid(b_bo_valid), .byte_out_ready(b_bo_ready),
        .byte_in_data(b_bi_data), .byte_in_valid(b_bi_valid), .byte_in_ready(b_bi_ready),
        .word_out_data(b_wo_data), .word_out_valid(b_wo_valid), .word_out_ready(b_wo_ready),
        .tx_busy(b_tx_busy), .rx_busy(b_rx_busy), .rx_timeout_err(b_err)
    );

    uart_word_serdes #(.DATA_W(8), .TIMEOUT_CYC(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .sw_rst(c_sw_rst),
        .word_in_data(c_wi_data), .word_in_valid(c_wi_valid), .word_in_ready(c_wi_ready),
        .byte_out_data(c_bo_data), .byte_out_valid(c_bo_valid), .byte_out_ready(c_bo_ready),
        .byte_in_data(c_bi_data), .byte_in_valid(c_bi_valid), .byte_in_ready(c_bi_ready),
        .word_out_data(c_wo_data), .word_out_valid(c_wo_valid), .word_out_ready(c_wo_ready),
        .tx_busy(c_tx_busy), .rx_busy(c_rx_busy), .rx_timeout_err(c_err)
    );

    typedef struct {
        logic [10:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } tx_vec_t;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [10:0] word;
    } rx_vec_t;

    tx_vec_t tx_tab[6];
    rx_vec_t rx_tab[6];

    // Reference-model state for the randomized run
    logic [7:0]  exp_bytes[$];
    logic [10:0] exp_words[$];
    logic [7:0]  rx_part[$];
    logic        tx_hs, bo_hs, bi_hs, wo_hs;
    int          gap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_tx_word(input logic [10:0] w, input logic [7:0] b0, input logic [7:0] b1);
        a_bo_ready = 1'b1;
        a_wi_data  = w;
        a_wi_valid = 1'b1;
        #1;
        check("tx_ready_idle", a_wi_ready, 1);
        step();
        a_wi_valid = 1'b0;
        check("tx_b0_valid", a_bo_valid, 1);
        check("tx_b0_data", a_bo_data, b0);
        check("tx_busy", a_tx_busy, 1);
        check("tx_ready_low1", a_wi_ready, 0);
        step();
        check("tx_b1_data", a_bo_data, b1);
        check("tx_ready_low2", a_wi_ready, 0);
        step();
        check("tx_done_valid", a_bo_valid, 0);
        check("tx_ready_again", a_wi_ready, 1);
        check("tx_idle_busy", a_tx_busy, 0);
    endtask

    task automatic a_rx_word(input logic [7:0] b0, input logic [7:0] b1, input logic [10:0] w);
        a_wo_ready = 1'b0;
        a_bi_valid = 1'b1;
        a_bi_data  = b0;
        #1;
        check("rx_ready", a_bi_ready, 1);
        step();
        a_bi_data = b1;
        check("rx_busy_partial", a_rx_busy, 1);
        step();
        a_bi_valid = 1'b0;
        check("rx_word_valid", a_wo_valid, 1);
        check("rx_word_data", a_wo_data, w);
        check("rx_hold_ready", a_bi_ready, 0);
        a_wo_ready = 1'b1;
        step();
        a_wo_ready = 1'b0;
        check("rx_consumed", a_wo_valid, 0);
    endtask

    initial begin
        logic [7:0] exp32[4];
        logic [7:0] rx32[4];
        logic [63:0] tmp;

        tx_tab[0] = '{11'h5A3, 8'hA3, 8'h05};
        tx_tab[1] = '{11'h7FF, 8'hFF, 8'h07};
        tx_tab[2] = '{11'h000, 8'h00, 8'h00};
        tx_tab[3] = '{11'h400, 8'h00, 8'h04};
        tx_tab[4] = '{11'h0FF, 8'hFF, 8'h00};
        tx_tab[5] = '{11'h123, 8'h23, 8'h01};
        rx_tab[0] = '{8'h34, 8'hFF, 11'h734};
        rx_tab[1] = '{8'h01, 8'h02, 11'h201};
        rx_tab[2] = '{8'hFF, 8'hFF, 11'h7FF};
        rx_tab[3] = '{8'h00, 8'h08, 11'h000};
        rx_tab[4] = '{8'hAB, 8'h03, 11'h3AB};
        rx_tab[5] = '{8'h55, 8'hF2, 11'h255};
        exp32 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rx32  = '{8'h78, 8'h56, 8'h34, 8'h12};

        {a_en, a_sw_rst, a_wi_valid, a_bo_ready, a_bi_valid, a_wo_ready} = '0;
        {b_en, b_sw_rst, b_wi_valid, b_bo_ready, b_bi_valid, b_wo_ready} = '0;
        {c_en, c_sw_rst, c_wi_valid, c_bo_ready, c_bi_valid, c_wo_ready} = '0;
        a_wi_data = '0; a_bi_data = '0;
        b_wi_data = '0; b_bi_data = '0;
        c_wi_data = '0; c_bi_data = '0;
        gap = 0;

        // Reset state
        #12;
        check("rst_wi_ready", a_wi_ready, 0);
        check("rst_bo_valid", a_bo_valid, 0);
        check("rst_bo_data", a_bo_data, 0);
        check("rst_bi_ready", a_bi_ready, 0);
        check("rst_wo_valid", a_wo_valid, 0);
        check("rst_wo_data", a_wo_data, 0);
        check("rst_busy", {a_tx_busy, a_rx_busy, a_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
        step();

        for (int i = 0; i < 6; i++) a_tx_word(tx_tab[i].word, tx_tab[i].b0, tx_tab[i].b1);
        for (int i = 0; i < 6; i++) a_rx_word(rx_tab[i].b0, rx_tab[i].b1, rx_tab[i].word);

        // TX backpressure: first byte held for 5 cycles
        a_bo_ready = 1'b0;
        a_wi_data  = 11'h5A3;
        a_wi_valid = 1'b1;
        step();
        a_wi_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", a_bo_data, 8'hA3);
            check("bp_hold_valid", a_bo_valid, 1);
            step();
        end
        a_bo_ready = 1'b1;
        #1;
        check("bp_release_data", a_bo_data, 8'hA3);
        step();
        check("bp_second_byte", a_bo_data, 8'h05);
        step();
        check("bp_done", a_bo_valid, 0);

        // RX hold: word held while consumer stalls, pending byte taken on return
        a_wo_ready = 1'b0;
        a_bi_valid = 1'b1;
        a_bi_data  = 8'h34;
        step();
        a_bi_data = 8'hFF;
        step();
        a_bi_data = 8'h99;
        for (int i = 0; i < 4; i++) begin
            check("hold_word", a_wo_data, 11'h734);
            check("hold_bi_ready", a_bi_ready, 0);
            step();
        end
        a_wo_ready = 1'b1;
        step();
        a_wo_ready = 1'b0;
        check("hold_return_ready", a_bi_ready, 1);
        check("hold_return_valid", a_wo_valid, 0);
        step();
        a_bi_data = 8'h01;
        check("hold_next_partial", a_rx_busy, 1);
        step();
        a_bi_valid = 1'b0;
        check("hold_next_word", a_wo_data, 11'h199);
        a_wo_ready = 1'b1;
        step();
        a_wo_ready = 1'b0;

        // Timeout: one byte then 16 idle cycles
        a_bi_valid = 1'b1;
        a_bi_data  = 8'h12;
        step();
        a_bi_valid = 1'b0;
        repeat (15) step();
        check("to_busy_before", a_rx_busy, 1);
        check("to_err_before", a_err, 0);
        step();
        check("to_busy_after", a_rx_busy, 0);
        check("to_err_after", a_err, 1);
        a_rx_word(8'h01, 8'h02, 11'h201);
        check("to_err_sticky", a_err, 1);

        // Soft reset during TX SEND (after first byte) and RX cnt=1
        a_bo_ready = 1'b1;
        a_wi_data  = 11'h5A3;
        a_wi_valid = 1'b1;
        step();
        a_wi_valid = 1'b0;
        a_bi_valid = 1'b1;
        a_bi_data  = 8'h12;
        step();
        check("sw_pre_byte", a_bo_data, 8'h05);
        check("sw_pre_rxbusy", a_rx_busy, 1);
        a_sw_rst   = 1'b1;
        a_bi_data  = 8'h34;
        a_wi_valid = 1'b1;
        a_wi_data  = 11'h7FF;
        #1;
        check("sw_bi_ready_gated", a_bi_ready, 0);
        check("sw_wi_ready_gated", a_wi_ready, 0);
        step();
        a_sw_rst   = 1'b0;
        a_bi_valid = 1'b0;
        a_wi_valid = 1'b0;
        check("sw_bo_valid", a_bo_valid, 0);
        check("sw_bo_data", a_bo_data, 0);
        check("sw_tx_busy", a_tx_busy, 0);
        check("sw_rx_busy", a_rx_busy, 0);
        check("sw_wo_valid", a_wo_valid, 0);
        check("sw_wo_data", a_wo_data, 0);
        check("sw_err", a_err, 0);
        a_tx_word(11'h123, 8'h23, 8'h01);
        a_rx_word(8'h56, 8'h04, 11'h456);

        // Byte arriving in the exact limit cycle wins over the timeout
        a_bi_valid = 1'b1;
        a_bi_data  = 8'hAA;
        step();
        a_bi_valid = 1'b0;
        repeat (15) step();
        check("win_busy", a_rx_busy, 1);
        a_bi_valid = 1'b1;
        a_bi_data  = 8'h07;
        step();
        a_bi_valid = 1'b0;
        check("win_word_valid", a_wo_valid, 1);
        check("win_word_data", a_wo_data, 11'h7AA);
        check("win_no_err", a_err, 0);
        a_wo_ready = 1'b1;
        step();
        a_wo_ready = 1'b0;

        // en falls during SEND: word completes, nothing new accepted
        a_bo_ready = 1'b1;
        a_wi_data  = 11'h3C5;
        a_wi_valid = 1'b1;
        step();
        a_en = 1'b0;
        a_wi_data = 11'h111;
        check("en_b0", a_bo_data, 8'hC5);
        step();
        check("en_b1", a_bo_data, 8'h03);
        check("en_b1_valid", a_bo_valid, 1);
        step();
        check("en_done_valid", a_bo_valid, 0);
        check("en_no_ready", a_wi_ready, 0);
        check("en_rx_ready", a_bi_ready, 0);
        step();
        check("en_no_accept", a_tx_busy, 0);
        a_wi_valid = 1'b0;
        a_en = 1'b1;
        step();

        // DATA_W=32 TX and RX (timeout disabled)
        b_bo_ready = 1'b1;
        b_wi_data  = 32'hDEADBEEF;
        b_wi_valid = 1'b1;
        step();
        b_wi_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("w32_tx_byte", b_bo_data, exp32[k]);
            check("w32_tx_ready_low", b_wi_ready, 0);
            step();
        end
        check("w32_tx_done", b_bo_valid, 0);
        b_bi_valid = 1'b1;
        b_bi_data  = rx32[0];
        step();
        b_bi_valid = 1'b0;
        repeat (40) step();
        check("w32_no_timeout_busy", b_rx_busy, 1);
        check("w32_no_timeout_err", b_err, 0);
        b_bi_valid = 1'b1;
        for (int k = 1; k < 4; k++) begin
            b_bi_data = rx32[k];
            step();
        end
        b_bi_valid = 1'b0;
        check("w32_rx_valid", b_wo_valid, 1);
        check("w32_rx_word", b_wo_data, 32'h12345678);
        b_wo_ready = 1'b1;
        step();
        b_wo_ready = 1'b0;

        // DATA_W=8: one byte per word
        c_bo_ready = 1'b1;
        c_wi_data  = 8'h5C;
        c_wi_valid = 1'b1;
        step();
        c_wi_valid = 1'b0;
        check("w8_tx_byte", c_bo_data, 8'h5C);
        step();
        check("w8_tx_done", c_bo_valid, 0);
        check("w8_tx_ready", c_wi_ready, 1);
        c_bi_valid = 1'b1;
        c_bi_data  = 8'h5C;
        step();
        c_bi_valid = 1'b0;
        check("w8_rx_valid", c_wo_valid, 1);
        check("w8_rx_word", c_wo_data, 8'h5C);
        check("w8_rx_busy", c_rx_busy, 0);
        c_wo_ready = 1'b1;
        step();
        c_wo_ready = 1'b0;

        // Randomized traffic on DUT a against a byte/word queue model
        a_bo_ready = 1'b0;
        a_wo_ready = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            automatic bit stim = (n < 2500);
            @(negedge clk);
            tx_hs = a_wi_valid && a_wi_ready;
            bo_hs = a_bo_valid && a_bo_ready;
            bi_hs = a_bi_valid && a_bi_ready;
            wo_hs = a_wo_valid && a_wo_ready;
            if (tx_hs) begin
                for (int k = 0; k < 2; k++) begin
                    tmp = 64'(a_wi_data) >> (8 * k);
                    exp_bytes.push_back(tmp[7:0]);
                end
            end
            if (bo_hs) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_tx_unexpected: got byte 0x%0h with none expected", a_bo_data);
                end else begin
                    check("rand_tx_byte", a_bo_data, exp_bytes.pop_front());
                end
            end
            if (bi_hs) begin
                rx_part.push_back(a_bi_data);
                if (rx_part.size() == 2) begin
                    tmp = '0;
                    foreach (rx_part[k]) tmp = tmp | (64'(rx_part[k]) << (8 * k));
                    exp_words.push_back(tmp[10:0]);
                    rx_part.delete();
                end
            end
            if (wo_hs) begin
                if (exp_words.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_rx_unexpected: got word 0x%0h with none expected", a_wo_data);
                end else begin
                    check("rand_rx_word", a_wo_data, exp_words.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (!a_wi_valid || tx_hs) begin
                a_wi_valid = stim && ($urandom_range(0, 2) != 0);
                a_wi_data  = 11'($urandom);
            end
            a_bo_ready = !stim || ($urandom_range(0, 3) != 0);
            if (!a_bi_valid || bi_hs) begin
                if (!(stim || rx_part.size() != 0)) begin
                    a_bi_valid = 1'b0;
                end else if (gap > 0) begin
                    a_bi_valid = 1'b0;
                    gap--;
                end else begin
                    a_bi_valid = 1'b1;
                    a_bi_data  = 8'($urandom);
                    gap = $urandom_range(0, 3);
                end
            end
            a_wo_ready = !stim || ($urandom_range(0, 2) != 0);
        end
        check("rand_tx_drained", exp_bytes.size(), 0);
        check("rand_rx_drained", exp_words.size(), 0);
        check("rand_rx_partial", rx_part.size(), 0);
        check("rand_no_timeout", a_err, 0);
        check("rand_tx_idle", a_tx_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
